// File: rtl/mem_master.sv
// mem_master: single-outstanding-request master for a simple synchronous RAM.
//
// A request is taken only in IDLE. A valid request (exactly one of req_rd /
// req_wr, address below DEPTH) walks SETUP -> STROBE -> HOLD -> DONE.
// Rejected requests (both directions, or address out of range) go straight
// to DONE with err raised and never touch the RAM.
//
// Ports:
//   clk, clr            clock, synchronous active-high reset
//   req_rd, req_wr      request direction, sampled in IDLE only
//   req_addr, req_wdata request word address and write data
//   busy                high in SETUP, STROBE and HOLD
//   done                one-cycle completion pulse
//   err                 one-cycle pulse with done for a rejected request
//   rdata               last successfully read word
//   mem_addr, mem_din   RAM address and write data, stable SETUP..HOLD
//   mem_read, mem_write RAM strobes, mutually exclusive
//   mem_dout            RAM read data (combinational from mem_addr/mem_read)
module mem_master #(
    parameter int DEPTH       = 512,
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        clr,
    input  logic        req_rd,
    input  logic        req_wr,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [31:0] rdata,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_din,
    output logic        mem_read,
    output logic        mem_write,
    input  logic [31:0] mem_dout
);

    // Strobe length is clamped into what the 4-bit counter can express.
    localparam int WAIT_EFF = (WAIT_CYCLES < 1)  ? 1  :
                              (WAIT_CYCLES > 15) ? 15 : WAIT_CYCLES;
    localparam logic [3:0]  LAST_CNT = 4'(WAIT_EFF - 1);
    localparam logic [31:0] DEPTH_W  = 32'(DEPTH);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        STROBE,
        HOLD,
        DONE
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q,   cnt_d;
    logic [31:0] addr_q,  addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        is_wr_q, is_wr_d;
    logic        err_q,   err_d;
    logic [31:0] rdata_q, rdata_d;

    logic any_req;
    logic bad_req;

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            is_wr_q <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            is_wr_q <= is_wr_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        is_wr_d = is_wr_q;
        err_d   = err_q;
        rdata_d = rdata_q;

        any_req = req_rd | req_wr;
        // Both directions at once is ambiguous; out-of-range would hit no RAM word.
        bad_req = (req_rd & req_wr) | (any_req & (req_addr >= DEPTH_W));

        unique case (state_q)
            IDLE: begin
                err_d = 1'b0;
                if (bad_req) begin
                    // Rejected requests leave the bus latches and rdata alone.
                    err_d   = 1'b1;
                    state_d = DONE;
                end else if (any_req) begin
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    is_wr_d = req_wr;
                    cnt_d   = 4'd0;
                    state_d = SETUP;
                end
            end
            SETUP: begin
                cnt_d   = 4'd0;
                state_d = STROBE;
            end
            STROBE: begin
                if (cnt_q == LAST_CNT) begin
                    // Capture on the edge that ends the final strobe cycle.
                    if (!is_wr_q) begin
                        rdata_d = mem_dout;
                    end
                    cnt_d   = 4'd0;
                    state_d = HOLD;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            HOLD: begin
                state_d = DONE;
            end
            DONE: begin
                err_d   = 1'b0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy      = (state_q == SETUP) || (state_q == STROBE) || (state_q == HOLD);
        done      = (state_q == DONE);
        err       = (state_q == DONE) && err_q;
        mem_read  = (state_q == STROBE) && !is_wr_q;
        mem_write = (state_q == STROBE) && is_wr_q;
        mem_addr  = addr_q;
        mem_din   = wdata_q;
        rdata     = rdata_q;
    end

endmodule

// File: tb/tb_mem_master.sv
// tb_mem_master: drives two mem_master instances (WAIT_CYCLES 1 and 3) with
// the same request stream. Each instance has its own behavioural RAM; a
// reference memory and per-instance expected rdata are kept in the bench and
// updated from the transaction rules only.
module tb_mem_master;

    logic        clk = 1'b0;
    logic        clr;
    logic        req_rd;
    logic        req_wr;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;

    logic [1:0]  busy_v;
    logic [1:0]  done_v;
    logic [1:0]  err_v;
    logic [1:0]  rd_v;
    logic [1:0]  wr_v;
    logic [31:0] rdata_v [2];
    logic [31:0] maddr_v [2];
    logic [31:0] mdin_v  [2];
    logic [31:0] mdout_v [2];

    logic [31:0] ram0 [512];
    logic [31:0] ram1 [512];
    logic        pre_we;
    logic [8:0]  pre_addr;
    logic [31:0] pre_data;

    logic [31:0] model_mem [512];
    logic [31:0] exp_rdata [2];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mem_master #(.DEPTH(512), .WAIT_CYCLES(1)) dut_w1 (
        .clk       (clk),
        .clr       (clr),
        .req_rd    (req_rd),
        .req_wr    (req_wr),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .busy      (busy_v[0]),
        .done      (done_v[0]),
        .err       (err_v[0]),
        .rdata     (rdata_v[0]),
        .mem_addr  (maddr_v[0]),
        .mem_din   (mdin_v[0]),
        .mem_read  (rd_v[0]),
        .mem_write (wr_v[0]),
        .mem_dout  (mdout_v[0])
    );

    mem_master #(.DEPTH(512), .WAIT_CYCLES(3)) dut_w3 (
        .clk       (clk),
        .clr       (clr),
        .req_rd    (req_rd),
        .req_wr    (req_wr),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .busy      (busy_v[1]),
        .done      (done_v[1]),
        .err       (err_v[1]),
        .rdata     (rdata_v[1]),
        .mem_addr  (maddr_v[1]),
        .mem_din   (mdin_v[1]),
        .mem_read  (rd_v[1]),
        .mem_write (wr_v[1]),
        .mem_dout  (mdout_v[1])
    );

    // Combinational-read RAMs; undriven data reads back as zero.
    assign mdout_v[0] = (rd_v[0] && maddr_v[0] < 32'd512) ? ram0[maddr_v[0][8:0]] : 32'h0;
    assign mdout_v[1] = (rd_v[1] && maddr_v[1] < 32'd512) ? ram1[maddr_v[1][8:0]] : 32'h0;

    // RAM write port, plus a preload path used while the masters sit in reset.
    always @(posedge clk) begin
        if (pre_we) begin
            ram0[pre_addr] <= pre_data;
            ram1[pre_addr] <= pre_data;
        end
        if (wr_v[0] && maddr_v[0] < 32'd512) ram0[maddr_v[0][8:0]] <= mdin_v[0];
        if (wr_v[1] && maddr_v[1] < 32'd512) ram1[maddr_v[1][8:0]] <= mdin_v[1];
    end

    // One request, then a fixed 14-cycle observation window per instance.
    // glitch_at / clr_at (cycle index after the accepting edge, 0 = none)
    // inject a stray request or a reset pulse during that window.
    task automatic run_txn(input string name, input logic rd, input logic wr,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           input int glitch_at, input int clr_at);
        bit   reject, aborted;
        int   w, exp_done_at, exp_done_cnt, exp_strb, exp_busy;
        int   n_rd [2];
        int   n_wr [2];
        int   n_done [2];
        int   done_at [2];
        int   n_busy [2];
        int   n_both [2];
        int   n_bad_bus [2];
        int   n_err_stray [2];
        logic err_at_done [2];

        reject  = (rd && wr) || (addr >= 32'd512);
        aborted = (clr_at > 0);
        for (int d = 0; d < 2; d++) begin
            n_rd[d] = 0; n_wr[d] = 0; n_done[d] = 0; done_at[d] = 0;
            n_busy[d] = 0; n_both[d] = 0; n_bad_bus[d] = 0; n_err_stray[d] = 0;
            err_at_done[d] = 1'b0;
        end

        @(negedge clk);
        req_rd = rd; req_wr = wr; req_addr = addr; req_wdata = wdata;
        @(negedge clk);
        req_rd = 1'b0; req_wr = 1'b0; req_addr = $urandom; req_wdata = $urandom;

        for (int k = 1; k <= 14; k++) begin
            if (k == glitch_at) begin
                req_rd   = 1'b1;
                req_addr = 32'($urandom_range(0, 511));
            end
            if (k == glitch_at + 1) req_rd = 1'b0;
            if (k == clr_at) clr = 1'b1;
            if (k == clr_at + 1) clr = 1'b0;
            for (int d = 0; d < 2; d++) begin
                if (rd_v[d]) n_rd[d]++;
                if (wr_v[d]) n_wr[d]++;
                if (rd_v[d] && wr_v[d]) n_both[d]++;
                if (busy_v[d]) begin
                    n_busy[d]++;
                    if (maddr_v[d] !== addr || mdin_v[d] !== wdata) n_bad_bus[d]++;
                end
                if (done_v[d]) begin
                    n_done[d]++;
                    if (done_at[d] == 0) begin
                        done_at[d]     = k;
                        err_at_done[d] = err_v[d];
                    end
                end
                if (err_v[d] && !done_v[d]) n_err_stray[d]++;
            end
            @(negedge clk);
        end

        for (int d = 0; d < 2; d++) begin
            w            = (d == 0) ? 1 : 3;
            exp_done_at  = reject ? 1 : w + 3;
            exp_done_cnt = (aborted && clr_at < exp_done_at) ? 0 : 1;
            exp_strb     = 0;
            exp_busy     = 0;
            if (!reject) begin
                for (int k = 2; k <= w + 1; k++)
                    if (!aborted || k <= clr_at) exp_strb++;
                for (int k = 1; k <= w + 2; k++)
                    if (!aborted || k <= clr_at) exp_busy++;
            end

            checks++;
            if (n_done[d] !== exp_done_cnt) begin
                errors++;
                $display("[TB] FAIL %s w%0d done_count: got %0d expected %0d", name, w, n_done[d], exp_done_cnt);
            end
            if (exp_done_cnt == 1) begin
                checks++;
                if (done_at[d] !== exp_done_at) begin
                    errors++;
                    $display("[TB] FAIL %s w%0d done_latency: got %0d expected %0d", name, w, done_at[d], exp_done_at);
                end
                checks++;
                if (err_at_done[d] !== reject) begin
                    errors++;
                    $display("[TB] FAIL %s w%0d err_flag: got %0b expected %0b", name, w, err_at_done[d], reject);
                end
            end
            checks++;
            if (n_rd[d] !== ((!reject && rd) ? exp_strb : 0)) begin
                errors++;
                $display("[TB] FAIL %s w%0d read_strobes: got %0d expected %0d", name, w, n_rd[d], (!reject && rd) ? exp_strb : 0);
            end
            checks++;
            if (n_wr[d] !== ((!reject && wr) ? exp_strb : 0)) begin
                errors++;
                $display("[TB] FAIL %s w%0d write_strobes: got %0d expected %0d", name, w, n_wr[d], (!reject && wr) ? exp_strb : 0);
            end
            checks++;
            if (n_busy[d] !== exp_busy) begin
                errors++;
                $display("[TB] FAIL %s w%0d busy_cycles: got %0d expected %0d", name, w, n_busy[d], exp_busy);
            end
            checks++;
            if (n_both[d] + n_bad_bus[d] + n_err_stray[d] !== 0) begin
                errors++;
                $display("[TB] FAIL %s w%0d bus_rules: got overlap=%0d unstable=%0d stray_err=%0d expected all 0",
                         name, w, n_both[d], n_bad_bus[d], n_err_stray[d]);
            end
        end

        // Reference update: a write lands once its strobe has seen an edge.
        if (!reject && wr && !(aborted && clr_at < 2)) model_mem[addr[8:0]] = wdata;
        for (int d = 0; d < 2; d++) begin
            if (aborted) exp_rdata[d] = 32'h0;
            else if (!reject && rd) exp_rdata[d] = model_mem[addr[8:0]];
            checks++;
            if (rdata_v[d] !== exp_rdata[d]) begin
                errors++;
                $display("[TB] FAIL %s dut%0d rdata: got %h expected %h", name, d, rdata_v[d], exp_rdata[d]);
            end
        end
    endtask

    // Preload RAM while held in reset with a request pending; reset must win.
    task automatic test_reset();
        logic [31:0] v;
        clr = 1'b1; req_rd = 1'b1; req_wr = 1'b0; req_addr = 32'd5; req_wdata = 32'h1234;
        pre_we = 1'b0; pre_addr = 9'd0; pre_data = 32'h0;
        for (int a = 0; a < 512; a++) begin
            @(negedge clk);
            v = (a == 43) ? 32'h2 : (a == 95) ? 32'hD : $urandom;
            pre_we = 1'b1; pre_addr = 9'(a); pre_data = v;
            model_mem[a] = v;
        end
        @(negedge clk);
        pre_we = 1'b0;
        for (int d = 0; d < 2; d++) begin
            exp_rdata[d] = 32'h0;
            checks++;
            if ({busy_v[d], done_v[d], err_v[d], rd_v[d], wr_v[d]} !== 5'b0) begin
                errors++;
                $display("[TB] FAIL reset dut%0d flags: got %b expected 00000", d,
                         {busy_v[d], done_v[d], err_v[d], rd_v[d], wr_v[d]});
            end
            checks++;
            if (maddr_v[d] !== 32'h0 || mdin_v[d] !== 32'h0 || rdata_v[d] !== 32'h0) begin
                errors++;
                $display("[TB] FAIL reset dut%0d regs: got addr=%h din=%h rdata=%h expected zeros",
                         d, maddr_v[d], mdin_v[d], rdata_v[d]);
            end
        end
        req_rd = 1'b0;
        clr = 1'b0;
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (busy_v[d] !== 1'b0) begin
                errors++;
                $display("[TB] FAIL reset_release dut%0d busy: got %b expected 0", d, busy_v[d]);
            end
        end
    endtask

    task automatic test_read_basic();
        run_txn("read43", 1'b1, 1'b0, 32'd43, 32'h0, 0, 0);
    endtask

    task automatic test_write_then_read();
        run_txn("write87", 1'b0, 1'b1, 32'd87, 32'hDEADBEEF, 0, 0);
        run_txn("read87", 1'b1, 1'b0, 32'd87, 32'h0, 0, 0);
    endtask

    task automatic test_wait_states();
        run_txn("read95", 1'b1, 1'b0, 32'd95, 32'h5A5A, 0, 0);
    endtask

    task automatic test_error();
        run_txn("err_addr600", 1'b1, 1'b0, 32'd600, 32'h0, 0, 0);
        run_txn("err_both10", 1'b1, 1'b1, 32'd10, 32'h77, 0, 0);
        run_txn("edge511", 1'b1, 1'b0, 32'd511, 32'h0, 0, 0);
        run_txn("edge512", 1'b1, 1'b0, 32'd512, 32'h0, 0, 0);
        run_txn("err_wr_huge", 1'b0, 1'b1, 32'hFFFF_FFFF, 32'hAB, 0, 0);
    endtask

    task automatic test_reset_mid_op();
        run_txn("abort_write", 1'b0, 1'b1, 32'd200, 32'hCAFEF00D, 0, 2);
        run_txn("after_abort", 1'b1, 1'b0, 32'd43, 32'h0, 0, 0);
    endtask

    task automatic test_busy_ignore();
        run_txn("busy_ignore", 1'b1, 1'b0, 32'd95, 32'h0, 2, 0);
    endtask

    task automatic test_random();
        int          sel;
        logic [31:0] a;
        for (int i = 0; i < 24; i++) begin
            sel = $urandom_range(0, 9);
            a   = ($urandom_range(0, 7) == 0) ? 32'($urandom_range(512, 700))
                                               : 32'($urandom_range(0, 511));
            if (sel == 0)      run_txn("rand_both", 1'b1, 1'b1, a, $urandom, 0, 0);
            else if (sel < 5)  run_txn("rand_read", 1'b1, 1'b0, a, $urandom, 0, 0);
            else               run_txn("rand_write", 1'b0, 1'b1, a, $urandom, 0, 0);
        end
        // Read back a handful of locations so random writes get observed.
        for (int i = 0; i < 8; i++)
            run_txn("rand_readback", 1'b1, 1'b0, 32'($urandom_range(0, 511)), 32'h0, 0, 0);
    endtask

    initial begin
        clr = 1'b1; req_rd = 1'b0; req_wr = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
        pre_we = 1'b0; pre_addr = 9'd0; pre_data = 32'h0;
        $display("[TB] start");
        test_reset();
        test_read_basic();
        test_write_then_read();
        test_wait_states();
        test_error();
        test_reset_mid_op();
        test_busy_ignore();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_master.md
MEM_MASTER -- requirements
Module: mem_master

Interface
REQ-001 Parameter: DEPTH, default 512, number of valid word addresses in the attached RAM.
REQ-002 Parameter: WAIT_CYCLES, default 1, range 1-15, cycles the read/write strobe is held.
REQ-003 clk  input  1  single clock, all state updates on rising edge.
REQ-004 clr  input  1  synchronous active-high reset.
REQ-005 req_rd  input  1  read request, sampled in IDLE only.
REQ-006 req_wr  input  1  write request, sampled in IDLE only.
REQ-007 req_addr  input  32  word address of the request.
REQ-008 req_wdata  input  32  write data of the request.
REQ-009 busy  output  1  high while a transaction is in progress.
REQ-010 done  output  1  one-cycle pulse at transaction completion.
REQ-011 err  output  1  one-cycle pulse, coincident with done, on a rejected request.
REQ-012 rdata  output  32  captured read data, held until the next successful read.
REQ-013 mem_addr  output  32  address to RAM.
REQ-014 mem_din  output  32  write data to RAM.
REQ-015 mem_read  output  1  RAM read strobe.
REQ-016 mem_write  output  1  RAM write strobe.
REQ-017 mem_dout  input  32  RAM read data, combinational from mem_addr/mem_read.

Function
REQ-018 FSM states: IDLE, SETUP, STROBE, HOLD, DONE.
REQ-019 IDLE: when exactly one of req_rd/req_wr is high, the block SHALL latch req_addr, req_wdata and direction, and go to SETUP.
REQ-020 IDLE with req_rd and req_wr both high, or req_addr >= DEPTH: the block SHALL go directly to DONE with err flagged, issue no strobe, and leave rdata unchanged.
REQ-021 SETUP (1 cycle): mem_addr and mem_din driven from the latches, both strobes low.
REQ-022 STROBE: the selected strobe SHALL be high for exactly WAIT_CYCLES cycles, counted by a 4-bit counter; the other strobe SHALL be low.
REQ-023 For reads, the block SHALL capture mem_dout into rdata on the clock edge ending the last STROBE cycle.
REQ-024 HOLD (1 cycle): strobes low, mem_addr and mem_din still held.
REQ-025 DONE (1 cycle): done=1, busy=0, then return to IDLE; a new request can be accepted the cycle after DONE.
REQ-026 busy SHALL be 1 in SETUP, STROBE and HOLD, and 0 in IDLE and DONE.
REQ-027 mem_read and mem_write SHALL never be high in the same cycle.
REQ-028 mem_addr/mem_din SHALL not change from SETUP through HOLD.
REQ-029 Requests arriving while not in IDLE SHALL be ignored and not queued.
REQ-030 Latency, valid access: request cycle to done pulse = WAIT_CYCLES + 3 cycles after the accepting edge; rejected request: done on the cycle after acceptance.
REQ-031 Out-of-range WAIT_CYCLES SHALL be clamped to 1 if 0 and to 15 if above 15.

Reset
REQ-032 clr=1 at a clock edge SHALL force IDLE, counter=0, busy=0, done=0, err=0, mem_read=0, mem_write=0, mem_addr=0, mem_din=0, rdata=0.
REQ-033 clr asserted mid-transaction SHALL abort it on that edge: strobes drop the next cycle, and no done pulse and no rdata update occur.
REQ-034 clr SHALL take priority over any simultaneous request.

Verification
REQ-035 Read: RAM[43]=2, WAIT_CYCLES=1, req_rd with addr 43 -> mem_read high for 1 cycle, done 4 cycles after acceptance, rdata=2, err=0.
REQ-036 Write then read: req_wr with addr 87, data 0xDEADBEEF -> mem_write high for 1 cycle with addr stable; subsequent read of 87 -> rdata=0xDEADBEEF.
REQ-037 Wait states: WAIT_CYCLES=3, read addr 95 (value 0xD) -> mem_read high for exactly 3 cycles, done 6 cycles after acceptance, rdata=0xD.
REQ-038 Error: req_rd with addr 600, then req_rd and req_wr together with addr 10 -> each gives done and err on the next cycle, with no strobe and rdata unchanged.
REQ-039 Reset mid-op: clr during STROBE of a write -> strobes low the next cycle, busy=0, no done pulse, and a following read completes normally.
REQ-040 Busy ignore: a second request pulsed during SETUP/STROBE -> exactly one done pulse and one strobe window.
